decoder_msg_packer: RTL and testbench

// - Downstream of the constant-weight decoder. Packs its serial message bits (bin_msg, qualified by ready) into OUT_W-bit words.
// - Writes the words to the output message FIFO. A terminator word carrying a valid-bit count ends the message on decoder done.
// - The decoder has no backpressure, so a one-word hold register absorbs FIFO stalls. Lost words set a sticky overflow flag.

---
 rtl/decoder_msg_packer.sv | 169 ++++++++++++++++
 tb/tb_decoder_msg_packer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_msg_packer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decoder_msg_packer                                           |
// | Description : Packs serial decoder message bits into OUT_W-bit FIFO words. |
// |               A terminator word carries the valid-bit count of the tail.   |
// |               Optional macro PACK_LSB_FIRST_EN: LSB-first packing with a   |
// |               right-aligned terminator (default MSB-first, left-aligned).  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module decoder_msg_packer #(
  parameter int OUT_W = 8,
  parameter int CNT_W = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             dec_done,
  input  logic             fifofull,
  output logic             writefifo,
  output logic [OUT_W-1:0] out_word,
  output logic             last,
  output logic [CNT_W-1:0] last_bits,
  output logic [LEN_W-1:0] bit_count,
  output logic             overflow,
  output logic             pack_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2,
    S_TERM    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] c_one_cnt  = CNT_W'(1);

  state_t             r_state;
  logic [OUT_W-1:0]   r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic [OUT_W-1:0]   r_hold;
  logic               r_hold_valid;
  logic               r_last;
  logic [CNT_W-1:0]   r_last_bits;
  logic [LEN_W-1:0]   r_bit_count;
  logic               r_overflow;
  logic               r_pack_done;

  logic               w_writefifo;
  logic               w_hold_free;
  logic               w_word_done;
  logic [CNT_W-1:0]   w_pad;
  logic [OUT_W-1:0]   w_sr_next;
  logic [OUT_W-1:0]   w_term;
  logic [LEN_W-1:0]   w_bc_inc;

  assign w_writefifo = r_hold_valid & ~fifofull;
  // The hold can take a new word if empty or if it is being written out right now.
  assign w_hold_free = ~r_hold_valid | w_writefifo;
  assign w_word_done = (r_cnt == (c_full_cnt - c_one_cnt));
  assign w_pad       = c_full_cnt - r_cnt;
  assign w_bc_inc    = (&r_bit_count) ? r_bit_count : (r_bit_count + LEN_W'(1));

`ifdef PACK_LSB_FIRST_EN
  assign w_sr_next = {bit_in, r_sr[OUT_W-1:1]};
  assign w_term    = r_sr >> w_pad;
`else
  assign w_sr_next = {r_sr[OUT_W-2:0], bit_in};
  assign w_term    = r_sr << w_pad;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= S_IDLE;
      r_sr         <= '0;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_last       <= 1'b0;
      r_last_bits  <= '0;
      r_bit_count  <= '0;
      r_overflow   <= 1'b0;
      r_pack_done  <= 1'b0;
    end else begin
      r_pack_done <= 1'b0;
      if (w_writefifo) begin
        r_hold_valid <= 1'b0;
      end

      if (start) begin
        // Abort or begin: any pending hold word is discarded.
        r_state      <= S_COLLECT;
        r_sr         <= '0;
        r_cnt        <= '0;
        r_hold       <= '0;
        r_hold_valid <= 1'b0;
        r_last       <= 1'b0;
        r_last_bits  <= '0;
        r_bit_count  <= '0;
        r_overflow   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end

          S_COLLECT: begin
            if (bit_valid) begin
              r_bit_count <= w_bc_inc;
              if (w_word_done) begin
                r_cnt <= '0;
                r_sr  <= '0;
                if (w_hold_free) begin
                  r_hold       <= w_sr_next;
                  r_hold_valid <= 1'b1;
                  r_last       <= 1'b0;
                  r_last_bits  <= c_full_cnt;
                end else begin
                  r_overflow <= 1'b1;
                end
              end else begin
                r_cnt <= r_cnt + c_one_cnt;
                r_sr  <= w_sr_next;
              end
            end
            if (dec_done) begin
              r_state <= S_FLUSH;
            end
          end

          S_FLUSH: begin
            if (w_hold_free) begin
              r_hold       <= w_term;
              r_hold_valid <= 1'b1;
              r_last       <= 1'b1;
              r_last_bits  <= r_cnt;
              r_state      <= S_TERM;
            end
          end

          S_TERM: begin
            if (w_writefifo) begin
              r_pack_done <= 1'b1;
              r_state     <= S_IDLE;
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign writefifo = w_writefifo;
  assign out_word  = r_hold;
  assign last      = r_last;
  assign last_bits = r_last_bits;
  assign bit_count = r_bit_count;
  assign overflow  = r_overflow;
  assign pack_done = r_pack_done;

endmodule
`default_nettype wire

// File: tb/tb_decoder_msg_packer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_decoder_msg_packer                                        |
// | Description : Scoreboard bench for decoder_msg_packer (OUT_W=8).           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_decoder_msg_packer;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic        bit_valid;
  logic        bit_in;
  logic        dec_done;
  logic        fifofull;
  logic        writefifo;
  logic [7:0]  out_word;
  logic        last;
  logic [3:0]  last_bits;
  logic [15:0] bit_count;
  logic        overflow;
  logic        pack_done;

  decoder_msg_packer #(.OUT_W(8), .CNT_W(4), .LEN_W(16)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .dec_done  (dec_done),
    .fifofull  (fifofull),
    .writefifo (writefifo),
    .out_word  (out_word),
    .last      (last),
    .last_bits (last_bits),
    .bit_count (bit_count),
    .overflow  (overflow),
    .pack_done (pack_done)
  );

`ifdef PACK_LSB_FIRST_EN
  localparam logic [7:0] c_exp_w1   = 8'h4D;
  localparam logic [7:0] c_exp_term = 8'h03;
`else
  localparam logic [7:0] c_exp_w1   = 8'hB2;
  localparam logic [7:0] c_exp_term = 8'hC0;
`endif

  typedef struct {
    logic [7:0] w;
    logic       l;
    logic [3:0] lb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic expect_pd = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] w, input logic l, input logic [3:0] lb);
    exp_t e;
    e.w = w; e.l = l; e.lb = lb;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input logic done_last);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_in    = bits[n-1-i];
      dec_done  = done_last && (i == n - 1);
      cyc();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    dec_done  = 1'b0;
  endtask

  // Monitor: every FIFO write is checked against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_b) begin
      if (expect_pd) begin
        chk("pack_done", pack_done, 1);
        expect_pd = 1'b0;
      end else if (pack_done) begin
        total++;
        bad++;
        $display("FAIL spurious_pack_done: got=1 expected=0 at %0t", $time);
      end
      if (writefifo) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got word=%0h last=%0b expected no write at %0t",
                   out_word, last, $time);
        end else begin
          e = q.pop_front();
          chk("out_word", out_word, e.w);
          chk("last", last, e.l);
          chk("last_bits", last_bits, e.lb);
          if (e.l) expect_pd = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    dec_done = 1'b0; fifofull = 1'b0;
    #12;
    chk("rst_writefifo", writefifo, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_last", last, 0);
    chk("rst_last_bits", last_bits, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_pack_done", pack_done, 0);
    cyc();
    rst_b = 1'b1;
    cyc();

    // Full word, then a 3-bit tail with dec_done on the last bit.
    pulse_start();
    push(c_exp_w1, 1'b0, 4'd8);
    send_bits(32'b10110010, 8, 1'b0);
    cyc();
    chk("t1_bit_count", bit_count, 8);
    push(c_exp_term, 1'b1, 4'd3);
    send_bits(32'b110, 3, 1'b1);
    repeat (6) cyc();
    chk("t2_bit_count", bit_count, 11);
    chk("t2_queue_empty", q.size(), 0);

    // IDLE ignores bits and dec_done.
    send_bits(32'hFF, 8, 1'b1);
    repeat (4) cyc();
    chk("idle_bit_count", bit_count, 11);

    // Exact word then dec_done: empty terminator; bits after dec_done ignored.
    pulse_start();
    push(8'hA5, 1'b0, 4'd8);
    push(8'h00, 1'b1, 4'd0);
    send_bits(32'hA5, 8, 1'b0);
    dec_done = 1'b1;
    cyc();
    dec_done = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (4) cyc();
    bit_valid = 1'b0; bit_in = 1'b0;
    repeat (3) cyc();
    chk("t3_bit_count", bit_count, 8);
    chk("t3_queue_empty", q.size(), 0);

    // FIFO stalled across three words: one kept, two dropped.
    pulse_start();
    fifofull = 1'b1;
    push(8'hFF, 1'b0, 4'd8);
    send_bits(32'hFFFFFF, 24, 1'b0);
    cyc();
    chk("t4_overflow", overflow, 1);
    chk("t4_bit_count", bit_count, 24);
    chk("t4_no_write_full", writefifo, 0);
    fifofull = 1'b0;
    repeat (4) cyc();
    chk("t4_queue_empty", q.size(), 0);
    chk("t4_overflow_sticky", overflow, 1);

    // Abort with a pending hold word under a full FIFO.
    pulse_start();
    fifofull = 1'b1;
    send_bits(32'hFFFFFF, 24, 1'b0);
    cyc();
    chk("t5_overflow_pre", overflow, 1);
    pulse_start();
    chk("t5_bit_count", bit_count, 0);
    chk("t5_overflow", overflow, 0);
    chk("t5_writefifo", writefifo, 0);
    fifofull = 1'b0;
    repeat (3) cyc();
    push(8'h3C, 1'b0, 4'd8);
    push(8'h00, 1'b1, 4'd0);
    send_bits(32'h3C, 8, 1'b0);
    dec_done = 1'b1;
    cyc();
    dec_done = 1'b0;
    repeat (6) cyc();
    chk("t5_bit_count_after", bit_count, 8);
    chk("final_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
